// File: rtl/mem_write_checker_pkg.sv
// Shared types for the store-stream checker: FSM states, fail codes and width helpers.
package memchk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_EMPTY    = 2'd3;

  // Index width that stays at least one bit for a single-entry table.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Observed data-memory write port of the core; the checker only listens (slave).
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;

  modport master (output MemWrite, DataAdr, WriteData);
  modport slave  (input  MemWrite, DataAdr, WriteData);
endinterface

// File: rtl/mem_write_checker_table.sv
// Expected-store table for mem_write_checker: append-only register file with
// fill count, sticky overflow flag and a combinational read port.
module memchk_table
  import memchk_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int IDX_W  = idx_width(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_adr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [IDX_W-1:0]  rd_ptr_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o,
  output logic [ADDR_W-1:0] rd_adr_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [ADDR_W-1:0] adr_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              full;
  logic              wr_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign wr_en = push_i && !full && !reset && !clear_i;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (push_i) begin
      if (full) ovf_q <= 1'b1;
      else      count_q <= count_q + CNT_W'(1);
    end
  end

  // Storage is not reset: entries at or beyond count are never read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      adr_q[count_q[IDX_W-1:0]]  <= push_adr_i;
      data_q[count_q[IDX_W-1:0]] <= push_data_i;
    end
  end

  assign count_o   = count_q;
  assign ovf_o     = ovf_q;
  assign rd_adr_o  = adr_q[rd_ptr_i];
  assign rd_data_o = data_q[rd_ptr_i];

endmodule

// File: rtl/mem_write_checker.sv
// Store-stream checker: compares observed stores in order against a loaded table.
// Optional RUN-cycle watchdog built only when MEMCHK_TIMEOUT_EN is defined.
module mem_write_checker
  import memchk_pkg::*;
#(
  parameter  int                ADDR_W         = 32,
  parameter  int                DATA_W         = 32,
  parameter  int                DEPTH          = 8,
  parameter  logic [ADDR_W-1:0] SCRATCH_ADR    = ADDR_W'(96),
  parameter  bit                SCRATCH_IGNORE = 1'b1,
  parameter  int                TIMEOUT        = 1000,
  localparam int                IDX_W          = idx_width(DEPTH),
  localparam int                CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                exp_push,
  input  logic [ADDR_W-1:0]   exp_adr,
  input  logic [DATA_W-1:0]   exp_data,
  input  logic                start,
  input  logic                clear,
  mem_write_checker_if.slave  st,
  output logic                done,
  output logic                pass,
  output logic [1:0]          fail_code,
  output logic [IDX_W-1:0]    fail_idx,
  output logic [ADDR_W-1:0]   fail_adr,
  output logic [DATA_W-1:0]   fail_data,
  output logic [CNT_W-1:0]    match_cnt,
  output logic [15:0]         scratch_cnt,
  output logic                load_ovf
);

  if (DEPTH < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("mem_write_checker: DEPTH and TIMEOUT must be at least 1");
  end

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  match_q;
  logic [15:0]       scratch_q;
  logic [1:0]        fc_q;
  logic [IDX_W-1:0]  fidx_q;
  logic [ADDR_W-1:0] fadr_q;
  logic [DATA_W-1:0] fdata_q;

  logic [CNT_W-1:0]  tbl_count;
  logic [ADDR_W-1:0] tbl_adr;
  logic [DATA_W-1:0] tbl_data;
  logic              tbl_push, tbl_clear;
  logic              is_scratch, is_match, is_last, wd_expire;

  assign tbl_push   = exp_push && (state_q == IDLE);
  assign tbl_clear  = clear && (state_q == PASS || state_q == FAIL);
  assign is_scratch = SCRATCH_IGNORE && (st.DataAdr == SCRATCH_ADR);
  assign is_match   = (st.DataAdr == tbl_adr) && (st.WriteData == tbl_data);
  assign is_last    = (CNT_W'(ptr_q) + CNT_W'(1)) == tbl_count;

  memchk_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (tbl_clear),
    .push_i      (tbl_push),
    .push_adr_i  (exp_adr),
    .push_data_i (exp_data),
    .rd_ptr_i    (ptr_q),
    .count_o     (tbl_count),
    .ovf_o       (load_ovf),
    .rd_adr_o    (tbl_adr),
    .rd_data_o   (tbl_data)
  );

`ifdef MEMCHK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;

  // Counts RUN cycles; held at zero outside RUN so each run starts fresh.
  always_ff @(posedge clk) begin
    if (reset || state_q != RUN) wd_q <= '0;
    else if (!wd_expire)         wd_q <= wd_q + WD_W'(1);
  end

  assign wd_expire = (state_q == RUN) && (wd_q == WD_W'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      match_q   <= '0;
      scratch_q <= '0;
      fc_q      <= FC_NONE;
      fidx_q    <= '0;
      fadr_q    <= '0;
      fdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q <= '0;
            if (tbl_count == '0 && !exp_push) begin
              state_q <= FAIL;
              fc_q    <= FC_EMPTY;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // A deciding store takes priority over a same-cycle watchdog expiry.
          if (st.MemWrite && !is_scratch) begin
            if (is_match) begin
              match_q <= match_q + CNT_W'(1);
              if (is_last) state_q <= PASS;
              else         ptr_q   <= ptr_q + IDX_W'(1);
            end else begin
              state_q <= FAIL;
              fc_q    <= FC_MISMATCH;
              fidx_q  <= ptr_q;
              fadr_q  <= st.DataAdr;
              fdata_q <= st.WriteData;
            end
          end else begin
            if (st.MemWrite && scratch_q != 16'hFFFF) scratch_q <= scratch_q + 16'd1;
            if (wd_expire) begin
              state_q <= FAIL;
              fc_q    <= FC_TIMEOUT;
              fidx_q  <= ptr_q;
              fadr_q  <= '0;
              fdata_q <= '0;
            end
          end
        end
        PASS, FAIL: begin
          if (clear) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            match_q   <= '0;
            scratch_q <= '0;
            fc_q      <= FC_NONE;
            fidx_q    <= '0;
            fadr_q    <= '0;
            fdata_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done        = (state_q == PASS) || (state_q == FAIL);
  assign pass        = (state_q == PASS);
  assign fail_code   = fc_q;
  assign fail_idx    = fidx_q;
  assign fail_adr    = fadr_q;
  assign fail_data   = fdata_q;
  assign match_cnt   = match_q;
  assign scratch_cnt = scratch_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized runs, all checked
// every cycle against a queue-based model of the checking rules.
module tb_mem_write_checker;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50;
`ifdef MEMCHK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exp_push = 1'b0;
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_data = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [1:0]  fail_idx;
  logic [31:0] fail_adr, fail_data;
  logic [2:0]  match_cnt;
  logic [15:0] scratch_cnt;
  logic        load_ovf;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_write_checker #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .exp_push   (exp_push),
    .exp_adr    (exp_adr),
    .exp_data   (exp_data),
    .start      (start),
    .clear      (clear),
    .st         (bus),
    .done       (done),
    .pass       (pass),
    .fail_code  (fail_code),
    .fail_idx   (fail_idx),
    .fail_adr   (fail_adr),
    .fail_data  (fail_data),
    .match_cnt  (match_cnt),
    .scratch_cnt(scratch_cnt),
    .load_ovf   (load_ovf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] q_adr[$];
  logic [31:0] q_dat[$];
  int          m_mode, m_ptr, m_match, m_scr, m_fc, m_fidx, m_runc;
  bit          m_ovf, m_decided;
  logic [31:0] m_fadr, m_fdat;

  task automatic model_reset();
    q_adr.delete(); q_dat.delete();
    m_mode = M_IDLE; m_ptr = 0; m_match = 0; m_scr = 0; m_fc = 0; m_fidx = 0;
    m_runc = 0; m_ovf = 0; m_fadr = '0; m_fdat = '0;
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else begin
      case (m_mode)
        M_IDLE: begin
          if (exp_push) begin
            if (q_adr.size() == DEPTH) m_ovf = 1;
            else begin q_adr.push_back(exp_adr); q_dat.push_back(exp_data); end
          end
          if (start) begin
            if (q_adr.size() == 0) begin m_mode = M_FAIL; m_fc = 3; end
            else begin m_mode = M_RUN; m_ptr = 0; m_runc = 0; end
          end
        end
        M_RUN: begin
          m_decided = 0;
          if (bus.MemWrite) begin
            if (bus.DataAdr == 32'd96) begin
              if (m_scr < 65535) m_scr++;
            end else if (bus.DataAdr == q_adr[m_ptr] && bus.WriteData == q_dat[m_ptr]) begin
              m_match++;
              if (m_ptr == q_adr.size() - 1) begin m_mode = M_PASS; m_decided = 1; end
              else m_ptr++;
            end else begin
              m_mode = M_FAIL; m_fc = 1; m_fidx = m_ptr;
              m_fadr = bus.DataAdr; m_fdat = bus.WriteData; m_decided = 1;
            end
          end
          if (TO_EN && !m_decided) begin
            m_runc++;
            if (m_runc == TIMEOUT) begin
              m_mode = M_FAIL; m_fc = 2; m_fidx = m_ptr; m_fadr = '0; m_fdat = '0;
            end
          end
        end
        default: if (clear) model_reset();
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done",        64'(done),        64'(m_mode == M_PASS || m_mode == M_FAIL));
      chk("pass",        64'(pass),        64'(m_mode == M_PASS));
      chk("fail_code",   64'(fail_code),   64'(m_fc));
      chk("fail_idx",    64'(fail_idx),    64'(m_fidx));
      chk("fail_adr",    64'(fail_adr),    64'(m_fadr));
      chk("fail_data",   64'(fail_data),   64'(m_fdat));
      chk("match_cnt",   64'(match_cnt),   64'(m_match));
      chk("scratch_cnt", 64'(scratch_cnt), 64'(m_scr));
      chk("load_ovf",    64'(load_ovf),    64'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(negedge clk); endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_push = 1; exp_adr = a; exp_data = d; tick(); exp_push = 0;
  endtask

  task automatic do_start(); start = 1; tick(); start = 0; endtask
  task automatic do_clear(); clear = 1; tick(); clear = 0; endtask
  task automatic do_reset(); reset = 1; tick(); reset = 0; endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite = 1; bus.DataAdr = a; bus.WriteData = d; tick(); bus.MemWrite = 0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin tick(); n++; end
    if (!done) chk({nm, "_wait_expired"}, 64'(n), 64'(budget + 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, k, r;
    bus.MemWrite = 0; bus.DataAdr = '0; bus.WriteData = '0;
    tick();
    chk_en = 1;
    reset = 0;
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_match", 64'(match_cnt), 64'(0));

    // Scratch stores tolerated, then the single expected store passes.
    push(100, 25); do_start();
    store(96, 3); store(96, 9);
    chk("t1_pass_before", 64'(pass), 64'(0));
    store(100, 25);
    chk("t1_pass", 64'(pass), 64'(1));
    chk("t1_scratch", 64'(scratch_cnt), 64'(2));
    do_clear();

    // Data mismatch.
    push(100, 25); do_start(); store(100, 24);
    chk("t2_code", 64'(fail_code), 64'(1));
    chk("t2_idx", 64'(fail_idx), 64'(0));
    chk("t2_adr", 64'(fail_adr), 64'(100));
    chk("t2_data", 64'(fail_data), 64'(24));
    do_clear();

    // Out-of-order store fails; in-order passes.
    push(100, 25); push(104, 7); do_start(); store(104, 7);
    chk("t3_code", 64'(fail_code), 64'(1));
    chk("t3_idx", 64'(fail_idx), 64'(0));
    do_clear();
    push(100, 25); push(104, 7); do_start(); store(100, 25); store(104, 7);
    chk("t3_pass", 64'(pass), 64'(1));
    chk("t3_match", 64'(match_cnt), 64'(2));
    do_clear();

    // Watchdog behaviour.
    push(100, 25); do_start();
`ifdef MEMCHK_TIMEOUT_EN
    wait_done("t4", 200, n);
    chk("t4_cycles", 64'(n), 64'(50));
    chk("t4_code", 64'(fail_code), 64'(2));
    do_clear();
    push(100, 25); do_start();
    repeat (49) tick();
    store(100, 25);
    chk("t4_edge_pass", 64'(pass), 64'(1));
    do_clear();
`else
    repeat (60) tick();
    chk("t4_no_timeout", 64'(done), 64'(0));
    do_reset();
`endif

    // Overflow: fifth push dropped, four matches complete the table.
    for (int i = 0; i < 5; i++) push(32'(200 + 4 * i), 32'(i));
    chk("t5_ovf", 64'(load_ovf), 64'(1));
    do_start();
    for (int i = 0; i < 4; i++) store(32'(200 + 4 * i), 32'(i));
    chk("t5_pass", 64'(pass), 64'(1));
    chk("t5_match", 64'(match_cnt), 64'(4));
    do_clear();
    do_start();
    chk("t5_empty", 64'(fail_code), 64'(3));
    do_clear();

    // Reset mid-run empties the table; idle stores are ignored.
    push(100, 25); push(104, 7); do_start(); store(100, 25);
    chk("t6_match_pre", 64'(match_cnt), 64'(1));
    do_reset();
    chk("t6_match", 64'(match_cnt), 64'(0));
    store(100, 25); store(104, 7);
    chk("t6_idle_done", 64'(done), 64'(0));
    do_start();
    chk("t6_empty", 64'(fail_code), 64'(3));
    do_clear();

    // Randomized runs.
    for (int it = 0; it < 60; it++) begin
      if (done) do_clear(); else do_reset();
      k = $urandom_range(0, 5);
      for (int i = 0; i < k; i++) begin
        r = $urandom_range(0, 7);
        push((r == 0) ? 32'd96 : 32'(100 + 4 * $urandom_range(0, 3)), 32'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 3) == 0) begin
        exp_push = 1; exp_adr = 32'(100 + 4 * $urandom_range(0, 3));
        exp_data = 32'($urandom_range(0, 3));
      end
      do_start(); exp_push = 0;
      for (int c = 0; c < 70 && !done; c++) begin
        r = $urandom_range(0, 9);
        if (r <= 3 && m_mode == M_RUN) begin
          bus.MemWrite = 1; bus.DataAdr = q_adr[m_ptr]; bus.WriteData = q_dat[m_ptr];
        end else if (r <= 5) begin
          bus.MemWrite = 1; bus.DataAdr = 96; bus.WriteData = $urandom;
        end else if (r == 6) begin
          bus.MemWrite = 1; bus.DataAdr = 32'(100 + 4 * $urandom_range(0, 3));
          bus.WriteData = 32'($urandom_range(0, 3));
        end else if (r == 7) begin
          exp_push = 1; exp_adr = $urandom; exp_data = $urandom; start = 1;
        end
        tick();
        bus.MemWrite = 0; exp_push = 0; start = 0;
      end
      if (done) begin
        start = 1; tick(); start = 0;
      end
    end

    do_reset();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Parametrised, synthesizable store-stream checker for the RISC-V pipeline benches. It observes the core's data-memory write port (MemWrite, DataAdr, WriteData) and compares every store against a programmed table of expected (address, data) pairs in order. Stores to a configurable scratch address are tolerated. The block reports pass or fail with a cause code, captures the offending store, and can enforce a cycle watchdog. It replaces hard-coded single-store checks in per-program testbenches.

## Interface
- ADDR_W, 32, width of DataAdr and table addresses
- DATA_W, 32, width of WriteData and table data
- DEPTH, 8, number of expected-store entries (≥1)
- SCRATCH_ADR, 96, address whose stores are ignored
- SCRATCH_IGNORE, 1, 1 = ignore stores to SCRATCH_ADR; 0 = treat them as ordinary stores
- TIMEOUT, 1000, watchdog limit in RUN cycles (used only with MEMCHK_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- exp_push  in  1  append {exp_adr, exp_data} to table (IDLE only)
- exp_adr  in  ADDR_W  expected address
- exp_data  in  DATA_W  expected data
- start  in  1  IDLE→RUN
- clear  in  1  PASS/FAIL→IDLE, empties table
- MemWrite  in  1  observed store strobe
- DataAdr  in  ADDR_W  observed store address
- WriteData  in  DATA_W  observed store data
- done  out  1  state is PASS or FAIL
- pass  out  1  state is PASS
- fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 empty table
- fail_idx  out  $clog2(DEPTH)  table index expected at failure
- fail_adr / fail_data  out  ADDR_W / DATA_W  captured offending store
- match_cnt  out  $clog2(DEPTH+1)  entries matched so far
- scratch_cnt  out  16  ignored scratch stores, saturating at 0xFFFF
- load_ovf  out  1  sticky: push attempted while table full

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: exp_push writes entry[count] and increments count. A push with count==DEPTH is dropped and sets load_ovf. Pushes outside IDLE are ignored.
- IDLE, start=1: if count (including a same-cycle push) is 0, go to FAIL with code 3. Otherwise go to RUN with ptr=0 and the watchdog at 0.
- RUN, per cycle with MemWrite=1:
  - If SCRATCH_IGNORE and DataAdr==SCRATCH_ADR: scratch_cnt++ and nothing else.
  - Else if {DataAdr, WriteData}==entry[ptr]: ptr++ and match_cnt++. If ptr was count-1, go to PASS.
  - Else go to FAIL with code 1, capturing fail_idx=ptr, fail_adr, and fail_data.
- RUN with MemWrite=0: no change apart from the watchdog.
- PASS/FAIL hold all outputs. clear returns to IDLE and zeroes count, ptr, match_cnt, scratch_cnt, load_ovf, fail_*, and fail_code. start is ignored in PASS/FAIL.
- Comparison uses full-width equality. X/Z on the inputs is not special-cased in RTL.

## Timing
- Reset values: state=IDLE, done=0, pass=0, fail_code=0, fail_idx=0, fail_adr=0, fail_data=0, match_cnt=0, scratch_cnt=0, load_ovf=0. The table contents are don't-care with count=0.
- Reset mid-RUN aborts immediately to IDLE with the table emptied.
- Stores are sampled on the rising edge. The store in the same cycle as start is not checked; checking begins the cycle after start.
- done, pass, and fail_* update on the edge that samples the deciding store, so they are visible one cycle after the store is presented.
- Simultaneous watchdog expiry and store: the store is evaluated first. A completing match gives PASS and a mismatch gives code 1. Timeout applies only if the store did not decide the outcome.
- ptr and count never wrap. ptr cannot exceed count-1 in RUN.

## Configuration
- MEMCHK_TIMEOUT_EN defined: a RUN-cycle counter of width $clog2(TIMEOUT+1) is built. On the TIMEOUT-th RUN cycle without a decision, go to FAIL with code 2, fail_idx=ptr, and fail_adr/fail_data=0.
- MEMCHK_TIMEOUT_EN undefined: no counter is built, RUN can last indefinitely, and code 2 is never produced. The TIMEOUT parameter is unused.

## Structure
- Package memchk_pkg holds the state enum (IDLE, RUN, PASS, FAIL) and the fail_code constants FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_EMPTY.
- Sub-module memchk_table is the DEPTH-entry register file. It provides push with count and overflow flag, a combinational read at ptr, and a clear.
- The FSM, counters, and capture registers live in mem_write_checker.

## Test plan
- Load (100,25), start, then store (96,3) and (96,9), then store (100,25) → scratch_cnt=2, PASS, pass=1 one cycle after the store.
- Load (100,25), store (100,24) → FAIL, fail_code=1, fail_idx=0, fail_adr=100, fail_data=24.
- Load (100,25) and (104,7), store (104,7) first → FAIL code 1, fail_idx=0. Repeat in order (100,25) then (104,7) → PASS, match_cnt=2.
- With MEMCHK_TIMEOUT_EN and TIMEOUT=50, load (100,25), no stores → FAIL code 2 exactly 50 cycles after RUN entry. Repeat with the matching store on cycle 50 → PASS.
- With DEPTH=4, push 5 entries → load_ovf=1 and count=4. Start with 0 entries (after clear) → FAIL code 3.
- Assert reset mid-RUN after one of two matches → next cycle state=IDLE, match_cnt=0, all outputs at reset values. Stores after that are ignored until start.
